// File: rtl/mano_seq_timer_pkg.sv
// mano_seq_timer_pkg
//   Shared definitions for the MANO timing-sequence generator:
//   controller FSM encodings and default SC geometry.
//   No ports (package).
package mano_seq_timer_pkg;

   localparam int SEQ_WIDTH_DEF = 4;
   localparam int MAX_T_DEF     = 15;

   typedef enum logic [1:0] {
      SEQ_ST_RUN    = 2'b00,
      SEQ_ST_HALTED = 2'b01,
      SEQ_ST_STEP   = 2'b10
   } seq_state_t;

endpackage

// File: rtl/mano_t_decoder.sv
// mano_t_decoder
//   Binary-to-one-hot decoder. Shared by the timing-signal bus and the
//   instruction-opcode decode path.
// Ports:
//   sel  in  SEQ_WIDTH       binary select
//   t    out 2**SEQ_WIDTH    one-hot output, bit sel high
module mano_t_decoder #(
   parameter int SEQ_WIDTH = 4
) (
   input  logic [SEQ_WIDTH-1:0]    sel,
   output logic [2**SEQ_WIDTH-1:0] t
);

   for (genvar gi = 0; gi < 2**SEQ_WIDTH; gi++) begin : g_dec
      assign t[gi] = (sel == SEQ_WIDTH'(gi));
   end

endmodule

// File: rtl/mano_seq_timer.sv
// mano_seq_timer
//   MANO timing-sequence generator: sequence counter SC with clear/load,
//   wrap-or-saturate at MAX_T, one-hot T bus, and a RUN/HALTED/STEP
//   controller.
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   en        in   count enable (used in RUN)
//   clr       in   SC <- 0 (highest priority after rst)
//   ld        in   SC <- ld_val
//   ld_val    in   load value
//   halt      in   request HALTED
//   start     in   request RUN (beats halt)
//   step_req  in   single-step request, acted on at its rising edge
//   sc        out  sequence count
//   t         out  one-hot decode of sc
//   tc        out  sc == MAX_T
//   running   out  controller in RUN
//   step_ack  out  pulse in the cycle after a STEP cycle
//   ovf       out  sticky wrap/saturate flag (only with MANO_SEQ_OVF_EN)
// Build option: define MANO_SEQ_OVF_EN to add the ovf output.
module mano_seq_timer
   import mano_seq_timer_pkg::*;
#(
   parameter int SEQ_WIDTH = SEQ_WIDTH_DEF,
   parameter int MAX_T     = MAX_T_DEF,
   parameter bit WRAP_MODE = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    clr,
   input  logic                    ld,
   input  logic [SEQ_WIDTH-1:0]    ld_val,
   input  logic                    halt,
   input  logic                    start,
   input  logic                    step_req,
   output logic [SEQ_WIDTH-1:0]    sc,
   output logic [2**SEQ_WIDTH-1:0] t,
   output logic                    tc,
   output logic                    running,
   output logic                    step_ack
`ifdef MANO_SEQ_OVF_EN
   ,
   output logic                    ovf
`endif
);

   localparam logic [SEQ_WIDTH-1:0] MAX_SC = SEQ_WIDTH'(MAX_T);

   seq_state_t           state_reg, state_next;
   logic [SEQ_WIDTH-1:0] sc_reg, sc_next;
   logic                 step_prev_reg;
   logic                 step_ack_reg;
   logic                 step_rise;
   logic                 inc;
   logic                 at_max;

   assign step_rise = step_req & ~step_prev_reg;
   assign at_max    = (sc_reg == MAX_SC);

   // Controller next state and increment qualifier
   always_comb begin
      state_next = state_reg;
      inc        = 1'b0;
      case (state_reg)
         SEQ_ST_RUN: begin
            inc = en;
            if (halt) state_next = SEQ_ST_HALTED;
         end
         SEQ_ST_HALTED: begin
            if (step_rise) state_next = SEQ_ST_STEP;
         end
         SEQ_ST_STEP: begin
            inc        = 1'b1;
            state_next = SEQ_ST_HALTED;
         end
         default: state_next = SEQ_ST_RUN;
      endcase
      if (start) state_next = SEQ_ST_RUN;
   end

   // SC next value: clr > ld > inc > hold. Values above MAX_T (only
   // reachable by load) simply count on modulo 2**SEQ_WIDTH.
   always_comb begin
      sc_next = sc_reg;
      if (clr) begin
         sc_next = '0;
      end else if (ld) begin
         sc_next = ld_val;
      end else if (inc) begin
         if (at_max) sc_next = WRAP_MODE ? '0 : MAX_SC;
         else        sc_next = sc_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= SEQ_ST_RUN;
         sc_reg        <= '0;
         step_prev_reg <= 1'b0;
         step_ack_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         sc_reg        <= sc_next;
         step_prev_reg <= step_req;
         // Acknowledge lands with the post-step sc, even if clr/ld won.
         step_ack_reg  <= (state_reg == SEQ_ST_STEP);
      end
   end

`ifdef MANO_SEQ_OVF_EN
   logic ovf_reg;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         ovf_reg <= 1'b0;
      end else if (!ld && inc && at_max) begin
         ovf_reg <= 1'b1;
      end
   end

   assign ovf = ovf_reg;
`endif

   mano_t_decoder #(
      .SEQ_WIDTH(SEQ_WIDTH)
   ) u_t_decoder (
      .sel(sc_reg),
      .t  (t)
   );

   assign sc       = sc_reg;
   assign tc       = at_max;
   assign running  = (state_reg == SEQ_ST_RUN);
   assign step_ack = step_ack_reg;

endmodule

// File: tb/tb_mano_seq_timer.sv
// tb_mano_seq_timer
//   Self-checking bench: two timers (default wrap at 15, and saturate at 7)
//   share one stimulus stream; a behavioural model predicts each of them.
module tb_mano_seq_timer;

   logic       clk = 1'b0;
   logic       rst, en, clr, ld, halt, start, step_req;
   logic [3:0] ld_val;

   logic [3:0]  sc0, sc1;
   logic [15:0] t0, t1;
   logic        tc0, tc1, run0, run1, ack0, ack1;
`ifdef MANO_SEQ_OVF_EN
   logic        ovf0, ovf1;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mano_seq_timer #(.SEQ_WIDTH(4), .MAX_T(15), .WRAP_MODE(1'b1)) dut_wrap (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .ld(ld), .ld_val(ld_val),
      .halt(halt), .start(start), .step_req(step_req),
      .sc(sc0), .t(t0), .tc(tc0), .running(run0), .step_ack(ack0)
`ifdef MANO_SEQ_OVF_EN
      , .ovf(ovf0)
`endif
   );

   mano_seq_timer #(.SEQ_WIDTH(4), .MAX_T(7), .WRAP_MODE(1'b0)) dut_sat (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .ld(ld), .ld_val(ld_val),
      .halt(halt), .start(start), .step_req(step_req),
      .sc(sc1), .t(t1), .tc(tc1), .running(run1), .step_ack(ack1)
`ifdef MANO_SEQ_OVF_EN
      , .ovf(ovf1)
`endif
   );

   // Behavioural model: mode 0 = running, 1 = halted, 2 = stepping.
   int m_sc[2], m_mode[2], m_prev[2], m_ack[2], m_ovf[2];
   int m_max[2]  = '{15, 7};
   int m_wrap[2] = '{1, 0};

   task automatic model_update();
      for (int i = 0; i < 2; i++) begin
         int advance, rise;
         if (rst) begin
            m_sc[i] = 0; m_mode[i] = 0; m_prev[i] = 0; m_ack[i] = 0; m_ovf[i] = 0;
         end else begin
            advance = (m_mode[i] == 0) ? int'(en) : (m_mode[i] == 2) ? 1 : 0;
            rise    = (step_req && m_prev[i] == 0) ? 1 : 0;
            m_ack[i]  = (m_mode[i] == 2) ? 1 : 0;
            m_prev[i] = int'(step_req);
            if (clr) m_ovf[i] = 0;
            else if (!ld && advance == 1 && m_sc[i] == m_max[i]) m_ovf[i] = 1;
            if (clr) m_sc[i] = 0;
            else if (ld) m_sc[i] = int'(ld_val);
            else if (advance == 1) begin
               if (m_sc[i] == m_max[i]) m_sc[i] = m_wrap[i] ? 0 : m_max[i];
               else m_sc[i] = (m_sc[i] + 1) % 16;
            end
            if (start) m_mode[i] = 0;
            else if (m_mode[i] == 0 && halt) m_mode[i] = 1;
            else if (m_mode[i] == 1 && rise == 1) m_mode[i] = 2;
            else if (m_mode[i] == 2) m_mode[i] = 1;
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 2; i++) begin
         logic [3:0]  s;
         logic [15:0] tt, one_hot;
         logic        c, r, a;
         s  = (i == 0) ? sc0  : sc1;
         tt = (i == 0) ? t0   : t1;
         c  = (i == 0) ? tc0  : tc1;
         r  = (i == 0) ? run0 : run1;
         a  = (i == 0) ? ack0 : ack1;
         one_hot = 16'd1 << m_sc[i];
         check($sformatf("sc[%0d]", i), 32'(s), m_sc[i]);
         check($sformatf("t[%0d]", i), 32'(tt), 32'(one_hot));
         check($sformatf("tc[%0d]", i), 32'(c), (m_sc[i] == m_max[i]) ? 1 : 0);
         check($sformatf("running[%0d]", i), 32'(r), (m_mode[i] == 0) ? 1 : 0);
         check($sformatf("step_ack[%0d]", i), 32'(a), m_ack[i]);
`ifdef MANO_SEQ_OVF_EN
         check($sformatf("ovf[%0d]", i), 32'((i == 0) ? ovf0 : ovf1), m_ovf[i]);
`endif
      end
   endtask

   // One clock: drive inputs (at negedge), advance model at posedge, check at negedge.
   task automatic cyc(input logic i_rst, i_en, i_clr, i_ld, input logic [3:0] i_val,
                      input logic i_halt, i_start, i_step);
      rst = i_rst; en = i_en; clr = i_clr; ld = i_ld; ld_val = i_val;
      halt = i_halt; start = i_start; step_req = i_step;
      @(posedge clk);
      model_update();
      @(negedge clk);
      check_all();
      $display("[TB] cyc rst=%0b en=%0b clr=%0b ld=%0b v=%0d h=%0b s=%0b st=%0b -> sc0=%0d sc1=%0d run=%0b ack=%0b",
               i_rst, i_en, i_clr, i_ld, i_val, i_halt, i_start, i_step, sc0, sc1, run0, ack0);
   endtask

   initial begin
      int acks;
      rst = 1'b1; en = 1'b0; clr = 1'b0; ld = 1'b0; ld_val = 4'd0;
      halt = 1'b0; start = 1'b0; step_req = 1'b0;
      @(negedge clk);

      // Reset state
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      check("reset_sc", 32'(sc0), 0);
      check("reset_t", 32'(t0), 1);
      check("reset_running", 32'(run0), 1);
      check("reset_tc_sat", 32'(tc1), 0);

      // Free count 17 cycles: wrap side goes round to 1, saturate side sticks at 7
      repeat (17) cyc(0, 1, 0, 0, 0, 0, 0, 0);
      check("wrap_after17", 32'(sc0), 1);
      check("sat_after17", 32'(sc1), 7);
      check("sat_tc", 32'(tc1), 1);
`ifdef MANO_SEQ_OVF_EN
      check("sat_ovf_set", 32'(ovf1), 1);
`endif
      cyc(0, 1, 1, 0, 0, 0, 0, 0);
      check("clr_sat_sc", 32'(sc1), 0);
`ifdef MANO_SEQ_OVF_EN
      check("clr_ovf", 32'(ovf1), 0);
`endif

      // clr beats ld beats en; then load above MAX_T on the saturating timer
      repeat (5) cyc(0, 1, 0, 0, 0, 0, 0, 0);
      check("at5", 32'(sc0), 5);
      cyc(0, 1, 1, 1, 9, 0, 0, 0);
      check("clr_wins", 32'(sc0), 0);
      cyc(0, 0, 0, 1, 9, 0, 0, 0);
      check("ld9_sc", 32'(sc0), 9);
      check("ld9_tc", 32'(tc0), 0);
      cyc(0, 1, 0, 0, 0, 0, 0, 0);
      check("above_max_inc", 32'(sc1), 10);

      // Halt, single step with held request, second step after re-arm
      cyc(0, 0, 1, 0, 0, 0, 0, 0);
      repeat (3) cyc(0, 1, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 0, 0);
      check("halted_running", 32'(run0), 0);
      repeat (3) cyc(0, 1, 0, 0, 0, 0, 0, 0);
      check("halted_hold", 32'(sc0), 3);
      acks = 0;
      for (int k = 0; k < 5; k++) begin
         cyc(0, 1, 0, 0, 0, 0, 0, 1);
         acks += int'(ack0);
      end
      check("step_once_sc", 32'(sc0), 4);
      check("step_once_acks", 32'(acks), 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      check("step_again", 32'(sc0), 5);

      // start beats halt; start from HALTED resumes next cycle
      cyc(0, 0, 0, 0, 0, 1, 1, 0);
      check("start_wins", 32'(run0), 1);
      cyc(0, 1, 0, 0, 0, 1, 1, 0);
      check("start_wins_count", 32'(sc0), 6);
      cyc(0, 0, 0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 1, 0);
      check("resume", 32'(run0), 1);

      // Reset during STEP cancels it
      cyc(0, 0, 0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0, 0, 0, 1);
      check("rst_step_sc", 32'(sc0), 0);
      check("rst_step_ack", 32'(ack0), 0);
      check("rst_step_run", 32'(run0), 1);

      // Random traffic against the model
      for (int k = 0; k < 400; k++) begin
         cyc(($urandom_range(63) == 0), 1'($urandom), ($urandom_range(15) == 0),
             ($urandom_range(15) == 0), 4'($urandom), ($urandom_range(9) == 0),
             ($urandom_range(11) == 0), ($urandom_range(2) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
